// File: rtl/mcu_subsys_pkg.sv
// Shared types and default memory map for the MCU subsystem bus router.
// The default map is ROM at index 0, SRAM at index 1 and peripherals at index 2.
package mcu_subsys_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK    = 32'hFFFF_C000;
  localparam logic [31:0] SRAM_BASE   = 32'h1000_0000;
  localparam logic [31:0] SRAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] PERIPH_MASK = 32'hF000_0000;

  localparam logic [95:0] DEF_TGT_BASE = {PERIPH_BASE, SRAM_BASE, ROM_BASE};
  localparam logic [95:0] DEF_TGT_MASK = {PERIPH_MASK, SRAM_MASK, ROM_MASK};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcu_subsys_addr_decode.sv
// Combinational priority address decoder: the lowest-index matching region wins.
module mcu_subsys_addr_decode
  import mcu_subsys_pkg::*;
#(
  parameter int                  N_TGT    = 3,
  parameter int                  IDX_W    = 2,
  parameter logic [N_TGT*32-1:0] TGT_BASE = DEF_TGT_BASE,
  parameter logic [N_TGT*32-1:0] TGT_MASK = DEF_TGT_MASK
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scanning from the top down lets lower indices overwrite higher ones.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if ((addr & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mcu_subsys_bus_router.sv
// Routes one CPU native-memory request at a time to a decoded target port,
// with timeout, error response and a sticky first-error address register.
module mcu_subsys_bus_router
  import mcu_subsys_pkg::*;
#(
  parameter int                  N_TGT       = 3,
  parameter logic [N_TGT*32-1:0] TGT_BASE    = DEF_TGT_BASE,
  parameter logic [N_TGT*32-1:0] TGT_MASK    = DEF_TGT_MASK,
  parameter int                  TIMEOUT_CYC = 255,
  parameter logic [31:0]         ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                cpu_mem_valid,
  input  logic [31:0]         cpu_mem_addr,
  input  logic [31:0]         cpu_mem_wdata,
  input  logic [3:0]          cpu_mem_wstrb,
  output logic                cpu_mem_ready,
  output logic [31:0]         cpu_mem_rdata,
  output logic [N_TGT-1:0]    tgt_mem_valid,
  output logic [31:0]         tgt_mem_addr,
  output logic [31:0]         tgt_mem_wdata,
  output logic [3:0]          tgt_mem_wstrb,
  input  logic [N_TGT-1:0]    tgt_mem_ready,
  input  logic [N_TGT*32-1:0] tgt_mem_rdata,
  output logic                bus_err,
  output logic [31:0]         bus_err_addr,
  input  logic                bus_err_clr
);

  localparam int IDX_W = idx_width(N_TGT);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_TGT-1:0] valid_nxt;
  logic [31:0]      addr_nxt, wdata_nxt, rdata_nxt, err_addr_nxt;
  logic [3:0]       wstrb_nxt;
  logic             ready_nxt, err_nxt, err_event;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             sel_ready;
  logic [31:0]      sel_rdata;

  mcu_subsys_addr_decode #(
    .N_TGT    (N_TGT),
    .IDX_W    (IDX_W),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .addr (cpu_mem_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Only the selected target's handshake is visible; the rest are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_ready = tgt_mem_ready[i];
        sel_rdata = tgt_mem_rdata[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    cnt_nxt      = cnt;
    valid_nxt    = tgt_mem_valid;
    addr_nxt     = tgt_mem_addr;
    wdata_nxt    = tgt_mem_wdata;
    wstrb_nxt    = tgt_mem_wstrb;
    ready_nxt    = 1'b0;
    rdata_nxt    = cpu_mem_rdata;
    err_event    = 1'b0;
    err_nxt      = bus_err & ~bus_err_clr;
    err_addr_nxt = bus_err_addr;

    case (state)
      IDLE: begin
        if (cpu_mem_valid) begin
          addr_nxt  = cpu_mem_addr;
          wdata_nxt = cpu_mem_wdata;
          wstrb_nxt = cpu_mem_wstrb;
          cnt_nxt   = '0;
          if (dec_hit) begin
            sel_nxt = dec_idx;
            for (int i = 0; i < N_TGT; i++) valid_nxt[i] = (dec_idx == IDX_W'(i));
            state_nxt = ACCESS;
          end else begin
            err_event = 1'b1;
            ready_nxt = 1'b1;
            rdata_nxt = ERR_RDATA;
            state_nxt = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          valid_nxt = '0;
          ready_nxt = 1'b1;
          rdata_nxt = sel_rdata;
          state_nxt = RESP;
        end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_LAST)) begin
          valid_nxt = '0;
          err_event = 1'b1;
          ready_nxt = 1'b1;
          rdata_nxt = ERR_RDATA;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A new error overrides a coincident clear and then owns the address slot.
    if (err_event) begin
      err_nxt = 1'b1;
      if (!bus_err || bus_err_clr) err_addr_nxt = addr_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sel           <= '0;
      cnt           <= '0;
      tgt_mem_valid <= '0;
      tgt_mem_addr  <= '0;
      tgt_mem_wdata <= '0;
      tgt_mem_wstrb <= '0;
      cpu_mem_ready <= 1'b0;
      cpu_mem_rdata <= '0;
      bus_err       <= 1'b0;
      bus_err_addr  <= '0;
    end else begin
      state         <= state_nxt;
      sel           <= sel_nxt;
      cnt           <= cnt_nxt;
      tgt_mem_valid <= valid_nxt;
      tgt_mem_addr  <= addr_nxt;
      tgt_mem_wdata <= wdata_nxt;
      tgt_mem_wstrb <= wstrb_nxt;
      cpu_mem_ready <= ready_nxt;
      cpu_mem_rdata <= rdata_nxt;
      bus_err       <= err_nxt;
      bus_err_addr  <= err_addr_nxt;
    end
  end

endmodule
